// File: rtl/trace_nop_pkg.sv
// rtl/trace_nop_pkg.sv - shared constants and event type for the l.nop trace collector
package trace_nop_pkg;

    localparam logic [7:0]  NOP_OPCODE = 8'h15;
    localparam logic [15:0] NOP_EXIT   = 16'h0001;
    localparam logic [15:0] NOP_REPORT = 16'h0002;
    localparam logic [15:0] NOP_PUTC   = 16'h0004;

    typedef struct packed {
        logic [15:0] code;
        logic [31:0] data;
        logic [31:0] pc;
    } trace_nop_event_t;

    function automatic logic is_sim_nop(input logic [7:0] opcode, input logic [15:0] code);
        return (opcode == NOP_OPCODE) &&
               ((code == NOP_EXIT) || (code == NOP_REPORT) || (code == NOP_PUTC));
    endfunction

endpackage

// File: rtl/trace_event_fifo.sv
// rtl/trace_event_fifo.sv - per-core event FIFO; a full FIFO accepts a push when popped in the same cycle
module trace_event_fifo
    import trace_nop_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  trace_nop_event_t push_data,
    input  logic             pop,
    output trace_nop_event_t pop_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    trace_nop_event_t mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    end

    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/trace_nop_event_collector.sv
// rtl/trace_nop_event_collector.sv - detects l.nop exit/report/putc per core, buffers and round-robin merges them
module trace_nop_event_collector
    import trace_nop_pkg::*;
#(
    parameter int NUM_CORES  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_CORES-1:0]   trace_valid,
    input  logic [NUM_CORES*32-1:0] trace_insn,
    input  logic [NUM_CORES*32-1:0] trace_pc,
    input  logic [NUM_CORES*32-1:0] r3,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [15:0]            out_core,
    output logic [15:0]            out_code,
    output logic [31:0]            out_data,
    output logic [31:0]            out_pc,
    output logic [NUM_CORES-1:0]   exited,
    output logic                   all_exited,
    output logic [NUM_CORES-1:0]   overflow
);

    localparam int RRW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic [NUM_CORES-1:0] det, det_exit, drop, pop;
    logic [NUM_CORES-1:0] fifo_empty, fifo_full;
    trace_nop_event_t     det_ev    [NUM_CORES];
    trace_nop_event_t     fifo_dout [NUM_CORES];
    logic                 unused_insn_bits;

    always_comb begin
        unused_insn_bits = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            det[i]      = trace_valid[i] &&
                          is_sim_nop(trace_insn[32*i+24 +: 8], trace_insn[32*i +: 16]);
            det_exit[i] = det[i] && (trace_insn[32*i +: 16] == NOP_EXIT);
            det_ev[i]   = '{code: trace_insn[32*i +: 16], data: r3[32*i +: 32], pc: trace_pc[32*i +: 32]};
            drop[i]     = det[i] && fifo_full[i] && !pop[i];
            unused_insn_bits = unused_insn_bits ^ (^trace_insn[32*i+16 +: 8]);
        end
    end

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
        trace_event_fifo #(
            .DEPTH(FIFO_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (det[g]),
            .push_data(det_ev[g]),
            .pop      (pop[g]),
            .pop_data (fifo_dout[g]),
            .empty    (fifo_empty[g]),
            .full     (fifo_full[g])
        );
    end

    logic [RRW-1:0] rr_q, rr_d, grant_idx, cand;
    logic           grant_any, load;

    // Scan offsets from the highest down so the candidate closest to rr wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            cand = RRW'((int'(rr_q) + k) % NUM_CORES);
            if (!fifo_empty[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    logic                 out_valid_q, out_valid_d;
    logic [15:0]          out_core_q, out_core_d;
    trace_nop_event_t     out_ev_q, out_ev_d;
    logic [NUM_CORES-1:0] exited_q, exited_d, overflow_q, overflow_d;
    logic                 all_exited_q, all_exited_d;

    always_comb begin
        load         = !out_valid_q || out_ready;
        out_valid_d  = out_valid_q;
        out_core_d   = out_core_q;
        out_ev_d     = out_ev_q;
        rr_d         = rr_q;
        pop          = '0;
        exited_d     = exited_q | det_exit;
        overflow_d   = overflow_q | drop;
        all_exited_d = &exited_q;
        if (load) begin
            out_valid_d = grant_any;
            if (grant_any) begin
                pop[grant_idx] = 1'b1;
                out_core_d     = 16'(grant_idx);
                out_ev_d       = fifo_dout[grant_idx];
                rr_d           = (grant_idx == RRW'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_core_q   <= '0;
            out_ev_q     <= '0;
            rr_q         <= '0;
            exited_q     <= '0;
            overflow_q   <= '0;
            all_exited_q <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_core_q   <= out_core_d;
            out_ev_q     <= out_ev_d;
            rr_q         <= rr_d;
            exited_q     <= exited_d;
            overflow_q   <= overflow_d;
            all_exited_q <= all_exited_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_core   = out_core_q;
    assign out_code   = out_ev_q.code;
    assign out_data   = out_ev_q.data;
    assign out_pc     = out_ev_q.pc;
    assign exited     = exited_q;
    assign overflow   = overflow_q;
    assign all_exited = all_exited_q;

endmodule

// File: tb/tb_trace_nop_event_collector.sv
// tb/tb_trace_nop_event_collector.sv - directed and random checks against a queue-based reference model
module tb_trace_nop_event_collector;

    localparam int N = 4;
    localparam int D = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   trace_valid;
    logic [N*32-1:0] trace_insn, trace_pc, r3;
    logic           out_valid, out_ready;
    logic [15:0]    out_core, out_code;
    logic [31:0]    out_data, out_pc;
    logic [N-1:0]   exited, overflow;
    logic           all_exited;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    trace_nop_event_collector #(.NUM_CORES(N), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .trace_valid(trace_valid), .trace_insn(trace_insn),
        .trace_pc(trace_pc), .r3(r3), .out_valid(out_valid), .out_ready(out_ready),
        .out_core(out_core), .out_code(out_code), .out_data(out_data), .out_pc(out_pc),
        .exited(exited), .all_exited(all_exited), .overflow(overflow)
    );

    logic [79:0]  mq [N][$];
    bit           m_valid;
    int           m_core;
    logic [79:0]  m_ev;
    int           m_rr;
    logic [N-1:0] m_exited, m_ovf;
    bit           m_all;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_evt(input logic [31:0] insn);
        return (insn[31:24] == 8'h15) &&
               (insn[15:0] == 16'd1 || insn[15:0] == 16'd2 || insn[15:0] == 16'd4);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) mq[i].delete();
        m_valid = 0; m_core = 0; m_ev = '0; m_rr = 0;
        m_exited = '0; m_ovf = '0; m_all = 0;
    endtask

    task automatic model_step();
        int g;
        logic [N-1:0] ex_prev;
        logic [31:0] insn;
        g = -1;
        ex_prev = m_exited;
        if (!m_valid || out_ready) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_rr + k) % N;
                if (g < 0 && mq[c].size() > 0) g = c;
            end
            m_valid = (g >= 0);
            if (g >= 0) begin
                m_core = g;
                m_ev   = mq[g].pop_front();
                m_rr   = (g + 1) % N;
            end
        end
        for (int i = 0; i < N; i++) begin
            insn = trace_insn[32*i +: 32];
            if (trace_valid[i] && is_evt(insn)) begin
                if (insn[15:0] == 16'd1) m_exited[i] = 1'b1;
                if (mq[i].size() < D) mq[i].push_back({insn[15:0], r3[32*i +: 32], trace_pc[32*i +: 32]});
                else m_ovf[i] = 1'b1;
            end
        end
        m_all = &ex_prev;
    endtask

    task automatic compare_all();
        chk("out_valid", 96'(out_valid), 96'(m_valid));
        if (m_valid) chk("out_event", {out_core, out_code, out_data, out_pc}, {16'(m_core), m_ev});
        chk("exited", 96'(exited), 96'(m_exited));
        chk("overflow", 96'(overflow), 96'(m_ovf));
        chk("all_exited", 96'(all_exited), 96'(m_all));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic clear_in();
        trace_valid = '0;
        trace_insn  = '0;
        trace_pc    = '0;
        r3          = '0;
    endtask

    task automatic set_ev(input int c, input logic [31:0] insn, input logic [31:0] d, input logic [31:0] pc);
        trace_valid[c]       = 1'b1;
        trace_insn[32*c +: 32] = insn;
        r3[32*c +: 32]         = d;
        trace_pc[32*c +: 32]   = pc;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_in();
        model_reset();
        #12;
        rst = 1'b0;
        #1;
        compare_all();
    endtask

    task automatic rr_burst(input string tag, input int first);
        out_ready = 1'b1;
        for (int c = 0; c < N; c++) set_ev(c, 32'h15000004, 32'h60 + c, 32'h400 + 4 * c);
        step();
        clear_in();
        step();
        for (int j = 0; j < N; j++) begin
            chk(tag, 96'(out_core), 96'((first + j) % N));
            step();
        end
        chk({tag, "_idle"}, 96'(out_valid), 96'd0);
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        clear_in();
        do_reset();
        chk("reset_outputs", {out_valid, all_exited, exited, overflow, out_core, out_code, out_data[15:0]}, '0);

        rr_burst("rr_from0", 0);

        set_ev(2, 32'h15000004, 32'h41, 32'h100);
        step();
        clear_in();
        chk("single_n1", 96'(out_valid), 96'd0);
        step();
        chk("single_valid", 96'(out_valid), 96'd1);
        chk("single_fields", {out_core, out_code, out_data, out_pc}, {16'd2, 16'd4, 32'h41, 32'h100});
        step();

        set_ev(0, 32'h15000003, 32'h11, 32'h200);
        set_ev(1, 32'h15100004, 32'h77, 32'h204);
        set_ev(2, 32'h9C000004, 32'h22, 32'h208);
        step();
        clear_in();
        step();
        chk("filter_event", {out_valid, out_core, out_code, out_data}, {1'b1, 16'd1, 16'd4, 32'h77});
        step();
        chk("filter_only_one", 96'(out_valid), 96'd0);

        rr_burst("rr_from2", 2);

        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            set_ev(0, 32'h15000002, 32'(i), 32'h300 + 32'(4 * i));
            step();
        end
        clear_in();
        step();
        chk("ovf_flag", 96'(overflow[0]), 96'd1);
        chk("ovf_held", {out_valid, out_data}, {1'b1, 32'd1});
        out_ready = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            chk("ovf_drain", {out_valid, out_data}, {1'b1, 32'(j)});
            step();
        end
        chk("ovf_drained", 96'(out_valid), 96'd0);

        do_reset();
        out_ready = 1'b1;
        foreach (m_exited[i]) begin
            int c;
            c = (i == 0) ? 3 : i - 1;
            set_ev(c, 32'h15000001, 32'h0, 32'h500);
            step();
            clear_in();
            chk("exit_bit", 96'(exited[c]), 96'd1);
        end
        chk("exit_all_pre", {exited, all_exited}, {4'hF, 1'b0});
        step();
        chk("exit_all", 96'(all_exited), 96'd1);

        out_ready = 1'b0;
        set_ev(0, 32'h15000002, 32'hA0, 32'h600);
        set_ev(1, 32'h15000002, 32'hA1, 32'h604);
        set_ev(3, 32'h15000002, 32'hA3, 32'h60C);
        step();
        clear_in();
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset", {out_valid, all_exited, exited, overflow, out_core, out_code, out_data, out_pc[15:0]}, '0);
        model_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            step();
            chk("post_reset_quiet", 96'(out_valid), 96'd0);
        end

        for (int cyc = 0; cyc < 400; cyc++) begin
            clear_in();
            out_ready = ($urandom_range(0, 2) != 0);
            for (int c = 0; c < N; c++) begin
                logic [31:0] insn;
                case ($urandom_range(0, 7))
                    0: insn = 32'h15000001;
                    1: insn = 32'h15000002;
                    2: insn = 32'h15000004;
                    3: insn = 32'h15000003;
                    4: insn = 32'h15FF0004;
                    5: insn = 32'h9C000004;
                    6: insn = 32'h15000002;
                    default: insn = $urandom;
                endcase
                if ($urandom_range(0, 1) == 1) set_ev(c, insn, $urandom, $urandom);
            end
            if (cyc == 200) begin
                do_reset();
            end else begin
                step();
            end
        end
        clear_in();
        for (int j = 0; j < 20; j++) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
